// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: decodes load/store ops, runs a
// req/ack transaction on a big-endian data bus, stalls the pipe while the
// access is in flight, and forwards load/ALU results towards MEM/WB.

package mem_access_pkg;
  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  input  logic        mem_whilo,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo,
  output logic        wb_whilo,
  output logic        stallreq_mem,
  output logic        align_err,
  output logic        bus_err
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rdata_q;
  logic          aborted_q;

  logic          is_load, is_store, need_half, need_word;
  logic          misaligned, access_ok;
  logic [1:0]    byte_off;
  logic [3:0]    sel_d;
  logic [31:0]   wdata_d;
  logic          issue, ack_done, timed_out, timeout_hit;
  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [31:0]   load_data;

  // Only the MEM/WB hold bit of the stall vector matters here.
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5], stall[3:0]};

  assign byte_off = mem_mem_addr[1:0];

  // Decode the op into load/store class and the alignment it needs.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    need_half = 1'b0;
    need_word = 1'b0;
    case (mem_aluop)
      EXE_LB_OP, EXE_LBU_OP: is_load = 1'b1;
      EXE_LH_OP, EXE_LHU_OP: begin is_load = 1'b1;  need_half = 1'b1; end
      EXE_LW_OP:             begin is_load = 1'b1;  need_word = 1'b1; end
      EXE_SB_OP:             is_store = 1'b1;
      EXE_SH_OP:             begin is_store = 1'b1; need_half = 1'b1; end
      EXE_SW_OP:             begin is_store = 1'b1; need_word = 1'b1; end
      default: ;
    endcase
  end

  assign misaligned = (need_half & mem_mem_addr[0]) | (need_word & (byte_off != 2'b00));
  assign access_ok  = (is_load | is_store) & ~misaligned;
  assign align_err  = misaligned;

  // Big-endian lane enables and replicated store data for the pending access.
  always_comb begin
    sel_d   = 4'b1000 >> byte_off;
    wdata_d = {4{mem_reg2[7:0]}};
    if (need_word) begin
      sel_d   = 4'b1111;
      wdata_d = mem_reg2;
    end else if (need_half) begin
      sel_d   = byte_off[1] ? 4'b0011 : 4'b1100;
      wdata_d = {2{mem_reg2[15:0]}};
    end
  end

  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == TO_LAST);

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; ack takes priority over a timeout on the same edge.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    ack_done  = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      ST_IDLE: if (access_ok) begin issue = 1'b1; state_d = ST_BUSY; end
      ST_BUSY: begin
        if (dbus_ack) begin
          ack_done = 1'b1;
          state_d  = ST_DONE;
        end else if (timeout_hit) begin
          timed_out = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: if (!stall[4]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign stallreq_mem = ((state_q == ST_IDLE) && access_ok) || (state_q == ST_BUSY);

  // Bus registers, timeout counter, read latch and error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_sel   <= '0;
      dbus_wdata <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      aborted_q  <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= timed_out;
      if (issue) begin
        dbus_req   <= 1'b1;
        dbus_we    <= is_store;
        dbus_addr  <= {mem_mem_addr[31:2], 2'b00};
        dbus_sel   <= sel_d;
        dbus_wdata <= wdata_d;
        cnt_q      <= '0;
        aborted_q  <= 1'b0;
      end
      if (state_q == ST_BUSY) cnt_q <= cnt_q + CW'(1);
      if (ack_done) begin
        dbus_req <= 1'b0;
        rdata_q  <= dbus_rdata;
      end
      if (timed_out) begin
        dbus_req  <= 1'b0;
        aborted_q <= 1'b1;
      end
    end
  end

  // Extract and extend the addressed byte/half from the latched word.
  always_comb begin
    case (byte_off)
      2'd0:    lane_byte = rdata_q[31:24];
      2'd1:    lane_byte = rdata_q[23:16];
      2'd2:    lane_byte = rdata_q[15:8];
      default: lane_byte = rdata_q[7:0];
    endcase
    lane_half = byte_off[1] ? rdata_q[15:0] : rdata_q[31:16];
    case (mem_aluop)
      EXE_LB_OP:  load_data = {{24{lane_byte[7]}}, lane_byte};
      EXE_LBU_OP: load_data = {24'h0, lane_byte};
      EXE_LH_OP:  load_data = {{16{lane_half[15]}}, lane_half};
      EXE_LHU_OP: load_data = {16'h0, lane_half};
      default:    load_data = rdata_q;
    endcase
  end

  // Result mux towards MEM/WB: passthrough unless a load or a rejected access.
  always_comb begin
    wb_wd    = mem_wd;
    wb_wreg  = mem_wreg;
    wb_wdata = mem_wdata;
    wb_hi    = mem_hi;
    wb_lo    = mem_lo;
    wb_whilo = mem_whilo;
    if (misaligned) begin
      wb_wreg = 1'b0;
    end else if (is_load) begin
      wb_wdata = load_data;
      wb_wreg  = ((state_q == ST_DONE) && !aborted_q) ? mem_wreg : 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// load/store traffic checked against a byte-lane model written from the bus rules.

module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int TO = 4;

  logic        clk, rst;
  logic [5:0]  stall;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr, mem_reg2;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata, wb_hi, wb_lo;
  logic        wb_whilo;
  logic        stallreq_mem, align_err, bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_unit #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
    .stallreq_mem(stallreq_mem), .align_err(align_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int op_size(logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
      EXE_LW_OP, EXE_SW_OP:             return 4;
      default:                          return 0;
    endcase
  endfunction

  function automatic bit is_load_op(logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  // Byte k of the word lives in bits [31-8k -: 8]; lane bit 3 is byte 0.
  function automatic logic [3:0] exp_sel(logic [7:0] op, logic [31:0] addr);
    int sz = op_size(op);
    int a  = int'(addr % 4);
    return 4'(((1 << sz) - 1) << (4 - sz - a));
  endfunction

  function automatic logic [31:0] exp_store(logic [7:0] op, logic [31:0] reg2);
    case (op_size(op))
      1:       return (reg2 & 32'hFF) * 32'h0101_0101;
      2:       return (reg2 & 32'hFFFF) * 32'h0001_0001;
      default: return reg2;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(logic [7:0] op, logic [31:0] addr, logic [31:0] word);
    int sz = op_size(op);
    int a  = int'(addr % 4);
    logic [31:0] mask, v;
    if (sz == 4) return word;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = (word >> (8 * (4 - sz - a))) & mask;
    if ((op == EXE_LB_OP || op == EXE_LH_OP) && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic wreg, input logic [31:0] alu);
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = reg2;
    mem_wreg     = wreg;
    mem_wdata    = alu;
    mem_wd       = 5'($urandom);
    mem_hi       = $urandom;
    mem_lo       = $urandom;
    mem_whilo    = 1'($urandom);
  endtask

  // One aligned access. ack_delay in 1..TO acks on that BUSY cycle; otherwise it times out.
  task automatic do_mem(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic wreg, input int ack_delay,
                        input logic [31:0] rdata, input int hold);
    bit load    = is_load_op(op);
    bit aborted = !(ack_delay >= 1 && ack_delay <= TO);
    int busy    = aborted ? TO : ack_delay;
    int stall_seen = 0;
    logic [31:0] alu = $urandom;
    logic        exp_wreg;
    logic [31:0] exp_wdata;

    @(negedge clk);
    set_op(op, addr, reg2, wreg, alu);
    stall = 6'b0; dbus_ack = 1'b0;
    #1;
    if (stallreq_mem) stall_seen++;
    if (dbus_req !== 1'b0) begin n_bad++; $display("FAIL %s idle_req: got %0b want 0", tag, dbus_req); end
    n_cmp++;
    if (align_err !== 1'b0) begin n_bad++; $display("FAIL %s align_err: got %0b want 0", tag, align_err); end
    n_cmp++;
    if (wb_wreg !== (load ? 1'b0 : wreg)) begin
      n_bad++; $display("FAIL %s idle_wreg: got %0b want %0b", tag, wb_wreg, load ? 1'b0 : wreg);
    end
    n_cmp++;

    for (int i = 0; i < busy; i++) begin
      @(negedge clk);
      dbus_ack = 1'b0;
      #1;
      if (stallreq_mem) stall_seen++;
      if (dbus_req !== 1'b1 || dbus_addr !== {addr[31:2], 2'b00} || dbus_sel !== exp_sel(op, addr) ||
          dbus_we !== !load || bus_err !== 1'b0) begin
        n_bad++;
        $display("FAIL %s busy%0d bus: got req=%0b we=%0b addr=%h sel=%b err=%0b want req=1 we=%0b addr=%h sel=%b err=0",
                 tag, i, dbus_req, dbus_we, dbus_addr, dbus_sel, bus_err, !load, {addr[31:2], 2'b00}, exp_sel(op, addr));
      end
      n_cmp++;
      if (!load) begin
        if (dbus_wdata !== exp_store(op, reg2)) begin
          n_bad++; $display("FAIL %s store_data: got %h want %h", tag, dbus_wdata, exp_store(op, reg2));
        end
        n_cmp++;
      end
      if (!aborted && i == busy - 1) begin
        dbus_ack = 1'b1; dbus_rdata = rdata;
      end else begin
        dbus_rdata = $urandom;
      end
    end

    @(negedge clk);
    dbus_ack = 1'b0;
    stall = (hold > 0) ? 6'b010000 : 6'b0;
    #1;
    exp_wreg  = (load && aborted) ? 1'b0 : wreg;
    exp_wdata = load ? exp_load(op, addr, rdata) : alu;
    if (stall_seen != 1 + busy) begin
      n_bad++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stall_seen, 1 + busy);
    end
    n_cmp++;
    if (dbus_req !== 1'b0 || stallreq_mem !== 1'b0 || bus_err !== aborted) begin
      n_bad++; $display("FAIL %s done_ctrl: got req=%0b stallreq=%0b err=%0b want 0 0 %0b",
                        tag, dbus_req, stallreq_mem, bus_err, aborted);
    end
    n_cmp++;
    if (wb_wreg !== exp_wreg) begin n_bad++; $display("FAIL %s done_wreg: got %0b want %0b", tag, wb_wreg, exp_wreg); end
    n_cmp++;
    if (!(load && aborted)) begin
      if (wb_wdata !== exp_wdata) begin n_bad++; $display("FAIL %s done_wdata: got %h want %h", tag, wb_wdata, exp_wdata); end
      n_cmp++;
    end
    if (wb_hi !== mem_hi || wb_lo !== mem_lo || wb_whilo !== mem_whilo || wb_wd !== mem_wd) begin
      n_bad++; $display("FAIL %s hilo_pass: got hi=%h lo=%h want hi=%h lo=%h", tag, wb_hi, wb_lo, mem_hi, mem_lo);
    end
    n_cmp++;

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (h == hold - 1) stall = 6'b0;
      #1;
      if (dbus_req !== 1'b0 || stallreq_mem !== 1'b0 || bus_err !== 1'b0 || wb_wreg !== exp_wreg) begin
        n_bad++; $display("FAIL %s hold%0d: got req=%0b stallreq=%0b err=%0b wreg=%0b want 0 0 0 %0b",
                          tag, h, dbus_req, stallreq_mem, bus_err, wb_wreg, exp_wreg);
      end
      n_cmp++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; stall = 6'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    set_op(EXE_NOP_OP, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    if (dbus_req !== 1'b0 || dbus_we !== 1'b0 || dbus_addr !== 32'h0 || dbus_sel !== 4'h0 ||
        dbus_wdata !== 32'h0 || bus_err !== 1'b0 || stallreq_mem !== 1'b0) begin
      n_bad++; $display("FAIL reset_state: got req=%0b we=%0b addr=%h sel=%b wdata=%h err=%0b stallreq=%0b want all 0",
                        dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata, bus_err, stallreq_mem);
    end
    n_cmp++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    set_op(EXE_NOP_OP, 32'h0, 32'h0, 1'b1, 32'h1234);
    #1;
    if (wb_wdata !== 32'h1234 || wb_wreg !== 1'b1 || dbus_req !== 1'b0 || stallreq_mem !== 1'b0) begin
      n_bad++; $display("FAIL nop_pass: got wdata=%h wreg=%0b req=%0b stallreq=%0b want 1234 1 0 0",
                        wb_wdata, wb_wreg, dbus_req, stallreq_mem);
    end
    n_cmp++;
    for (int k = 0; k < 6; k++) begin
      logic [7:0] op;
      do op = 8'($urandom); while (op_size(op) != 0);
      @(negedge clk);
      set_op(op, $urandom, $urandom, 1'($urandom), $urandom);
      dbus_ack = 1'b1;
      #1;
      if (wb_wdata !== mem_wdata || wb_wreg !== mem_wreg || wb_wd !== mem_wd || wb_hi !== mem_hi ||
          wb_lo !== mem_lo || wb_whilo !== mem_whilo || stallreq_mem !== 1'b0 || align_err !== 1'b0) begin
        n_bad++; $display("FAIL alu_pass op=%h: got wdata=%h wreg=%0b stallreq=%0b want %h %0b 0",
                          op, wb_wdata, wb_wreg, stallreq_mem, mem_wdata, mem_wreg);
      end
      n_cmp++;
    end
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    if (dbus_req !== 1'b0 || bus_err !== 1'b0) begin
      n_bad++; $display("FAIL stray_ack: got req=%0b err=%0b want 0 0", dbus_req, bus_err);
    end
    n_cmp++;
  endtask

  task automatic test_directed();
    do_mem("lb_101", EXE_LB_OP, 32'h101, 32'h0, 1'b1, 1, 32'h11F2_3344, 0);
    do_mem("sh_202", EXE_SH_OP, 32'h202, 32'hAAAA_BEEF, 1'b0, 4, 32'h0, 0);
    do_mem("lhu_102", EXE_LHU_OP, 32'h102, 32'h0, 1'b1, 1, 32'h0000_8001, 0);
    do_mem("lw_to", EXE_LW_OP, 32'h100, 32'h0, 1'b1, 0, 32'h0, 1);
    do_mem("lh_hold", EXE_LH_OP, 32'h3002, 32'h0, 1'b1, 2, 32'h1234_F00D, 3);
  endtask

  task automatic test_misaligned();
    logic [7:0]  ops   [5] = '{EXE_LW_OP, EXE_SW_OP, EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
    logic [31:0] addrs [5] = '{32'h103, 32'h402, 32'h501, 32'h603, 32'h701};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_op(ops[k], addrs[k], $urandom, 1'b1, $urandom);
      #1;
      if (align_err !== 1'b1 || stallreq_mem !== 1'b0 || wb_wreg !== 1'b0 || dbus_req !== 1'b0) begin
        n_bad++; $display("FAIL misalign op=%h addr=%h: got err=%0b stallreq=%0b wreg=%0b req=%0b want 1 0 0 0",
                          ops[k], addrs[k], align_err, stallreq_mem, wb_wreg, dbus_req);
      end
      n_cmp++;
      @(negedge clk);
      #1;
      if (dbus_req !== 1'b0) begin n_bad++; $display("FAIL misalign_noreq op=%h: got %0b want 0", ops[k], dbus_req); end
      n_cmp++;
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [8] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    for (int k = 0; k < 24; k++) begin
      logic [7:0]  op   = ops[$urandom_range(0, 7)];
      logic [31:0] addr = $urandom & ~(32'(op_size(op)) - 32'd1);
      do_mem($sformatf("rnd%0d", k), op, addr, $urandom, 1'($urandom),
             $urandom_range(0, TO + 1), $urandom, $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    set_op(EXE_LW_OP, 32'h840, 32'h0, 1'b1, 32'h0);
    @(posedge clk);
    #2;
    if (dbus_req !== 1'b1) begin n_bad++; $display("FAIL pre_rst_req: got %0b want 1", dbus_req); end
    n_cmp++;
    rst = 1'b1;
    set_op(EXE_NOP_OP, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    if (dbus_req !== 1'b0 || dbus_sel !== 4'h0 || dbus_addr !== 32'h0 || stallreq_mem !== 1'b0) begin
      n_bad++; $display("FAIL async_rst: got req=%0b sel=%b addr=%h stallreq=%0b want 0 0 0 0",
                        dbus_req, dbus_sel, dbus_addr, stallreq_mem);
    end
    n_cmp++;
    @(negedge clk);
    rst = 1'b0;
    do_mem("post_rst", EXE_SB_OP, 32'h843, 32'h0000_00A5, 1'b0, 1, 32'h0, 0);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_directed();
    test_misaligned();
    test_random();
    test_reset_mid_busy();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
